// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the ID/EX issue logic: opcodes, shift funct fields
// and the shifter's type codes.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        SH_SRL  = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_PASS = 2'b11
    } shift_type_e;

    function automatic logic writes_rd(input logic [6:0] opc);
        return (opc == OPC_OP)  || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
               (opc == OPC_LUI) || (opc == OPC_AUIPC)  || (opc == OPC_JAL)  ||
               (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// EX-stage operand forwarding: EX/MEM result beats MEM/WB result beats register data.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      src_idx_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic            exmem_regwrite_i,
    input  logic [4:0]      exmem_rd_i,
    input  logic [XLEN-1:0] exmem_result_i,
    input  logic            memwb_regwrite_i,
    input  logic [4:0]      memwb_rd_i,
    input  logic [XLEN-1:0] memwb_result_i,
    output logic [XLEN-1:0] data_o
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == src_idx_i);
    assign hit_memwb = memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == src_idx_i);

    assign data_o = hit_exmem ? exmem_result_i :
                    hit_memwb ? memwb_result_i : reg_data_i;

endmodule

// File: rtl/id_ex_shift_issue.sv
// ID/EX pipeline register with shift decode, operand forwarding, load-use bubble
// insertion and a retired-shift counter for the EX-stage shifter.
module id_ex_shift_issue
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            exmem_regwrite,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [4:0]      ex_shamt,
    output logic [1:0]      ex_type,
    output logic            ex_is_shift,
    output logic            ex_illegal,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic [31:0]     shift_count
);

    logic            valid_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic            is_load_q;
    logic            regwrite_q;
    logic [31:0]     shift_count_q;
    logic [31:0]     shift_count_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    shift_type_e     type_w;
    logic [4:0]      shamt_w;
    logic            is_shift_w;
    logic            illegal_w;

    // Only the rs2 field of register-register ops names a real source register.
    assign hazard_stall = valid_q && is_load_q && (rd_q != 5'd0) &&
                          ((rd_q == id_rs1) || ((rd_q == id_rs2) && (id_opcode == OPC_OP)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            is_load_q  <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            if (hazard_stall) begin
                valid_q <= 1'b0;
            end else begin
                valid_q    <= id_valid;
                opcode_q   <= id_opcode;
                funct3_q   <= id_funct3;
                funct7_q   <= id_funct7;
                rs1_q      <= id_rs1;
                rs2_q      <= id_rs2;
                rd_q       <= id_rd;
                rs1_data_q <= id_rs1_data;
                rs2_data_q <= id_rs2_data;
                imm_q      <= id_imm;
                is_load_q  <= (id_opcode == OPC_LOAD);
                regwrite_q <= writes_rd(id_opcode);
            end
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .src_idx_i        (rs1_q),
        .reg_data_i       (rs1_data_q),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .data_o           (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .src_idx_i        (rs2_q),
        .reg_data_i       (rs2_data_q),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .data_o           (rs2_fwd)
    );

    always_comb begin
        type_w     = SH_PASS;
        shamt_w    = 5'd0;
        is_shift_w = 1'b0;
        illegal_w  = 1'b0;
        if (valid_q && ((opcode_q == OPC_OP) || (opcode_q == OPC_OP_IMM)) &&
            ((funct3_q == F3_SLL) || (funct3_q == F3_SRX))) begin
            if (funct7_q == F7_BASE) begin
                is_shift_w = 1'b1;
                type_w     = (funct3_q == F3_SLL) ? SH_SLL : SH_SRL;
            end else if ((funct7_q == F7_ALT) && (funct3_q == F3_SRX)) begin
                is_shift_w = 1'b1;
                type_w     = SH_SRA;
            end else begin
                illegal_w  = 1'b1;
            end
            if (is_shift_w) begin
                shamt_w = (opcode_q == OPC_OP) ? rs2_fwd[4:0] : imm_q[4:0];
            end
        end
    end

    assign shift_count_d = shift_count_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_count_q <= '0;
        end else if (is_shift_w && !stall) begin
            shift_count_q <= shift_count_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_a        = rs1_fwd;
    assign ex_shamt    = shamt_w;
    assign ex_type     = type_w;
    assign ex_is_shift = is_shift_w;
    assign ex_illegal  = illegal_w;
    assign ex_rd       = rd_q;
    assign ex_regwrite = valid_q && regwrite_q;
    assign shift_count = shift_count_q;

    logic unused_bits;
    assign unused_bits = ^{imm_q[XLEN-1:5], rs2_fwd[XLEN-1:5]};

endmodule

// File: tb/tb_id_ex_shift_issue.sv
// Directed bench for id_ex_shift_issue: decode, forwarding, load-use bubbles,
// flush/stall priority, reset during stall and shift counter wrap.
module tb_id_ex_shift_issue;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid;
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        hazard_stall, ex_valid, ex_is_shift, ex_illegal, ex_regwrite;
    logic [31:0] ex_a, shift_count;
    logic [4:0]  ex_shamt, ex_rd;
    logic [1:0]  ex_type;

    int total = 0;
    int bad   = 0;

    id_ex_shift_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_a(ex_a),
        .ex_shamt(ex_shamt), .ex_type(ex_type), .ex_is_shift(ex_is_shift),
        .ex_illegal(ex_illegal), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm);
        id_valid = v;   id_opcode = opc; id_funct3 = f3; id_funct7 = f7;
        id_rs1 = r1;    id_rs2 = r2;     id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
        drive_id(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        #3;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_type",  32'(ex_type),  32'd3);
        chk("rst_a",     ex_a,          32'd0);
        chk("rst_cnt",   shift_count,   32'd0);
        chk("rst_haz",   32'(hazard_stall), 32'd0);
        tick();
        rst = 1'b0;

        // SRAI x2, x1, 4
        drive_id(1'b1, 7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd4, 5'd2,
                 32'h8000_0010, 32'd0, 32'd4);
        tick();
        chk("srai_valid", 32'(ex_valid),    32'd1);
        chk("srai_a",     ex_a,             32'h8000_0010);
        chk("srai_shamt", 32'(ex_shamt),    32'd4);
        chk("srai_type",  32'(ex_type),     32'd2);
        chk("srai_shift", 32'(ex_is_shift), 32'd1);
        chk("srai_ill",   32'(ex_illegal),  32'd0);
        chk("srai_rd",    32'(ex_rd),       32'd2);
        chk("srai_rw",    32'(ex_regwrite), 32'd1);

        // SLL x6, x3, x5 with forwarding on both sources
        drive_id(1'b1, 7'b0110011, 3'b001, 7'b0000000, 5'd3, 5'd5, 5'd6,
                 32'h0000_00F0, 32'h0000_001F, 32'd0);
        tick();
        chk("cnt_after_srai", shift_count, 32'd1);
        chk("sll_type", 32'(ex_type), 32'd1);
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h23;
        #1;
        chk("fwd_exmem_shamt", 32'(ex_shamt), 32'd3);
        chk("fwd_exmem_a",     ex_a,          32'h0000_00F0);
        memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'd7;
        #1;
        chk("fwd_both_shamt", 32'(ex_shamt), 32'd3);
        exmem_regwrite = 1'b0;
        #1;
        chk("fwd_memwb_shamt", 32'(ex_shamt), 32'd7);
        memwb_rd = 5'd3; memwb_result = 32'h0000_ABCD;
        #1;
        chk("fwd_memwb_a",  ex_a,          32'h0000_ABCD);
        chk("fwd_none_sh",  32'(ex_shamt), 32'd31);
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; exmem_rd = 5'd0;

        // SRLI with upper immediate bits set; only imm[4:0] counts
        drive_id(1'b1, 7'b0010011, 3'b101, 7'b0000000, 5'd1, 5'd0, 5'd9,
                 32'h1234_5678, 32'd0, 32'h0000_07E1);
        tick();
        chk("cnt_after_sll", shift_count,   32'd2);
        chk("srli_shamt",    32'(ex_shamt), 32'd1);
        chk("srli_type",     32'(ex_type),  32'd0);

        // SLLI with funct7 0100000 is malformed
        drive_id(1'b1, 7'b0010011, 3'b001, 7'b0100000, 5'd1, 5'd0, 5'd9,
                 32'd0, 32'd0, 32'd3);
        tick();
        chk("cnt_after_srli", shift_count,    32'd3);
        chk("ill_flag",       32'(ex_illegal), 32'd1);
        chk("ill_shift",      32'(ex_is_shift), 32'd0);
        chk("ill_type",       32'(ex_type),    32'd3);

        // Load-use: LW x7 then SRL x8, x7, x9
        drive_id(1'b1, 7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd7,
                 32'd0, 32'd0, 32'd0);
        tick();
        chk("lw_is_shift", 32'(ex_is_shift), 32'd0);
        drive_id(1'b1, 7'b0010011, 3'b000, 7'b0000000, 5'd1, 5'd7, 5'd8,
                 32'd0, 32'd0, 32'd0);
        #1;
        chk("haz_rs2_opimm", 32'(hazard_stall), 32'd0);
        drive_id(1'b1, 7'b0110011, 3'b101, 7'b0000000, 5'd7, 5'd9, 5'd8,
                 32'h0000_0100, 32'd2, 32'd0);
        #1;
        chk("haz_set", 32'(hazard_stall), 32'd1);
        tick();
        chk("haz_bubble", 32'(ex_valid),     32'd0);
        chk("haz_clear",  32'(hazard_stall), 32'd0);
        tick();
        chk("haz_issue_valid", 32'(ex_valid),    32'd1);
        chk("haz_issue_shift", 32'(ex_is_shift), 32'd1);
        chk("haz_issue_rd",    32'(ex_rd),       32'd8);
        chk("cnt_before_flush", shift_count,     32'd3);

        // Flush together with hazard: one bubble only
        drive_id(1'b1, 7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd7,
                 32'd0, 32'd0, 32'd0);
        tick();
        chk("cnt_after_srl", shift_count, 32'd4);
        drive_id(1'b1, 7'b0110011, 3'b101, 7'b0000000, 5'd7, 5'd9, 5'd8,
                 32'h0000_0100, 32'd2, 32'd0);
        flush = 1'b1;
        #1;
        chk("flush_haz_req", 32'(hazard_stall), 32'd1);
        tick();
        flush = 1'b0;
        chk("flush_bubble", 32'(ex_valid), 32'd0);
        tick();
        chk("flush_one_bubble", 32'(ex_valid), 32'd1);
        chk("flush_cnt",        shift_count,   32'd4);

        // Stall together with hazard: load is held, hazard stays up
        drive_id(1'b1, 7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd7,
                 32'd0, 32'd0, 32'd0);
        tick();
        drive_id(1'b1, 7'b0110011, 3'b101, 7'b0000000, 5'd7, 5'd9, 5'd8,
                 32'h0000_0100, 32'd2, 32'd0);
        stall = 1'b1;
        tick();
        chk("stall_hold_valid", 32'(ex_valid),     32'd1);
        chk("stall_hold_rd",    32'(ex_rd),        32'd7);
        chk("stall_haz",        32'(hazard_stall), 32'd1);
        chk("stall_cnt",        shift_count,       32'd5);

        // Reset in the middle of the stall
        rst = 1'b1;
        #1;
        chk("rst_stall_valid", 32'(ex_valid),     32'd0);
        chk("rst_stall_type",  32'(ex_type),      32'd3);
        chk("rst_stall_rd",    32'(ex_rd),        32'd0);
        chk("rst_stall_rw",    32'(ex_regwrite),  32'd0);
        chk("rst_stall_haz",   32'(hazard_stall), 32'd0);
        chk("rst_stall_cnt",   shift_count,       32'd0);
        rst = 1'b0;
        stall = 1'b0;
        tick();
        chk("post_rst_load",  32'(ex_valid),    32'd1);
        chk("post_rst_shift", 32'(ex_is_shift), 32'd1);
        chk("post_rst_cnt",   shift_count,      32'd0);

        // Shift held under stall does not count; then wrap from all-ones
        stall = 1'b1;
        tick();
        chk("stall_no_count", shift_count, 32'd0);
        force dut.shift_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.shift_count_q;
        #1;
        stall = 1'b0;
        tick();
        chk("cnt_wrap", shift_count, 32'd0);

        // id_valid low: issued slot is empty and qualifies the outputs
        drive_id(1'b0, 7'b0110011, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd3,
                 32'd0, 32'd0, 32'd0);
        tick();
        chk("inv_valid", 32'(ex_valid),    32'd0);
        chk("inv_shift", 32'(ex_is_shift), 32'd0);
        chk("inv_rw",    32'(ex_regwrite), 32'd0);
        chk("inv_cnt",   shift_count,      32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
